// File: rtl/sram_emulator_pkg.sv
// rtl/sram_emulator_pkg.sv - shared SRAM geometry, state encoding and pin decode helper
package sram_emulator_pkg;

    localparam int         SRAM_ADDR_W          = 13;
    localparam int         SRAM_DEPTH           = 2 ** SRAM_ADDR_W;
    localparam logic [7:0] SRAM_INVALID_PATTERN = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        READ_ACC,
        READ_VALID,
        WRITE,
        COMMIT
    } sram_state_t;

    // A real SRAM lets WE override OE, so a read needs WE high.
    function automatic logic is_read(input logic ce, input logic oe, input logic we);
        return ce & oe & ~we;
    endfunction

endpackage

// File: rtl/sram_emulator_if.sv
// rtl/sram_emulator_if.sv - async SRAM pin bundle between sram_driver and the emulator
interface sram_emulator_if
    import sram_emulator_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W
);
    logic              n_ce1;
    logic              n_we;
    logic              n_oe;
    logic [ADDR_W-1:0] address;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              data_oe;

    modport master (
        output n_ce1, n_we, n_oe, address, data_in,
        input  data_out, data_oe
    );

    modport slave (
        input  n_ce1, n_we, n_oe, address, data_in,
        output data_out, data_oe
    );
endinterface

// File: rtl/sram_emu_mem.sv
// rtl/sram_emu_mem.sv - single-port sync block RAM, 1-cycle registered read, write-first
module sram_emu_mem #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    logic [7:0] mem [2 ** ADDR_W];

    // No reset: contents must survive a reset of the emulator.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/sram_emulator.sv
// rtl/sram_emulator.sv - 8Kx8 async SRAM responder with programmable access time
module sram_emulator
    import sram_emulator_pkg::*;
#(
    parameter int         ACCESS_CYCLES   = 4,
    parameter int         SYNC_STAGES     = 2,
    parameter int         ADDR_W          = SRAM_ADDR_W,
    parameter logic [7:0] INVALID_PATTERN = SRAM_INVALID_PATTERN
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_emulator_if.slave        sram,
    output logic [15:0]           write_count,
    output logic                  violation
);
    localparam int                PIN_W         = 3 + ADDR_W + 8;
    localparam int                CNT_W         = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST      = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [PIN_W-1:0]  PINS_INACTIVE = {3'b111, {(ADDR_W + 8){1'b0}}};

    logic [PIN_W-1:0]  pins_raw;
    logic [PIN_W-1:0]  pins_s;

    assign pins_raw = {sram.n_ce1, sram.n_we, sram.n_oe, sram.address, sram.data_in};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign pins_s = pins_raw;
        end else begin : g_sync
            logic [PIN_W-1:0] stage [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        stage[i] <= PINS_INACTIVE;
                    end
                end else begin
                    stage[0] <= pins_raw;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign pins_s = stage[SYNC_STAGES-1];
        end
    endgenerate

    logic              ce;
    logic              we;
    logic              oe;
    logic [ADDR_W-1:0] addr_s;
    logic [7:0]        din_s;
    logic              rd_req;
    logic              wr_req;

    assign ce     = ~pins_s[PIN_W-1];
    assign we     = ~pins_s[PIN_W-2];
    assign oe     = ~pins_s[PIN_W-3];
    assign addr_s = pins_s[ADDR_W+7:8];
    assign din_s  = pins_s[7:0];
    assign rd_req = is_read(ce, oe, we);
    assign wr_req = ce & we;

    sram_state_t       state;
    sram_state_t       state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              latch_wr;
    logic              viol_set;
    logic              mem_we;
    logic              addr_changed;
    logic              data_oe_q;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_q;

    assign addr_changed = (addr_s != last_addr);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        latch_wr = 1'b0;
        viol_set = 1'b0;
        mem_we   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    state_n  = WRITE;
                    latch_wr = 1'b1;
                end else if (rd_req) begin
                    state_n = READ_ACC;
                    cnt_n   = '0;
                end
            end
            READ_ACC: begin
                if (wr_req) begin
                    state_n  = WRITE;
                    latch_wr = 1'b1;
                end else if (!rd_req) begin
                    state_n = IDLE;
                end else if (addr_changed) begin
                    cnt_n = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = READ_VALID;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            READ_VALID: begin
                if (wr_req) begin
                    state_n  = WRITE;
                    latch_wr = 1'b1;
                end else if (!rd_req) begin
                    state_n = IDLE;
                end else if (addr_changed) begin
                    state_n = READ_ACC;
                    cnt_n   = '0;
                end
            end
            WRITE: begin
                // The edge that ends the write is not latched: commit uses the prior cycle.
                if (wr_req) begin
                    latch_wr = 1'b1;
                    viol_set = (addr_s != wr_addr);
                end else begin
                    state_n = COMMIT;
                end
            end
            COMMIT: begin
                mem_we = 1'b1;
                if (wr_req) begin
                    state_n  = WRITE;
                    latch_wr = 1'b1;
                end else if (rd_req) begin
                    state_n = READ_ACC;
                    cnt_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last_addr   <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            data_oe_q   <= 1'b0;
            write_count <= '0;
            violation   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            last_addr <= addr_s;
            data_oe_q <= rd_req;
            if (latch_wr) begin
                wr_addr <= addr_s;
                wr_data <= din_s;
            end
            if (mem_we) begin
                write_count <= write_count + 16'd1;
            end
            if (viol_set) begin
                violation <= 1'b1;
            end
        end
    end

    // The RAM is read every cycle so its 1-cycle latency hides inside the access count.
    assign mem_addr = (state == COMMIT) ? wr_addr : addr_s;

    sram_emu_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (wr_data),
        .rdata (mem_q)
    );

    assign sram.data_out = (state == READ_VALID) ? mem_q : INVALID_PATTERN;
    assign sram.data_oe  = data_oe_q;

endmodule

// File: tb/tb_sram_emulator.sv
// tb/tb_sram_emulator.sv - directed bench for sram_emulator with a cycle-level reference model
module tb_sram_emulator;
    localparam int         AW  = 13;
    localparam logic [7:0] INV = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] write_count;
    logic        violation;

    sram_emulator_if #(.ADDR_W(AW)) bus ();

    sram_emulator #(
        .ACCESS_CYCLES   (4),
        .SYNC_STAGES     (0),
        .ADDR_W          (AW),
        .INVALID_PATTERN (INV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sram        (bus),
        .write_count (write_count),
        .violation   (violation)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: a read is valid once the same read request has been seen on
    // five consecutive edges; a write commits on the edge after the one that ends it.
    logic [7:0]    m_mem   [2**AW];
    bit            m_known [2**AW];
    int            m_run       = 0;
    bit            m_wr_active = 1'b0;
    bit            m_pend      = 1'b0;
    logic [AW-1:0] m_wa        = '0;
    logic [7:0]    m_wd        = '0;
    logic [AW-1:0] m_prev      = '0;
    logic [AW-1:0] m_cur       = '0;
    logic [15:0]   m_count     = '0;
    bit            m_viol      = 1'b0;
    bit            m_oe        = 1'b0;
    logic [7:0]    m_do        = INV;
    bit            m_do_known  = 1'b1;

    initial begin
        for (int i = 0; i < 2**AW; i++) m_known[i] = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_run = 0; m_wr_active = 0; m_pend = 0;
                m_count = '0; m_viol = 0; m_oe = 0;
            end else begin
                bit rd, wr;
                rd = !bus.n_ce1 && !bus.n_oe && bus.n_we;
                wr = !bus.n_ce1 && !bus.n_we;
                if (m_pend) begin
                    m_mem[m_wa]   = m_wd;
                    m_known[m_wa] = 1'b1;
                    m_count       = m_count + 16'd1;
                    m_pend        = 1'b0;
                end
                if (wr) begin
                    if (m_wr_active && bus.address != m_wa) m_viol = 1'b1;
                    m_wa = bus.address; m_wd = bus.data_in;
                    m_wr_active = 1'b1; m_run = 0;
                end else if (m_wr_active) begin
                    m_wr_active = 1'b0; m_pend = 1'b1; m_run = 0;
                end else if (rd) begin
                    m_run = (m_run > 0 && bus.address == m_prev) ? ((m_run < 5) ? m_run + 1 : 5) : 1;
                end else begin
                    m_run = 0;
                end
                m_prev = bus.address;
                m_cur  = bus.address;
                m_oe   = rd;
            end
            m_do       = (m_run >= 5) ? m_mem[m_cur] : INV;
            m_do_known = (m_run < 5) || m_known[m_cur];
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc_data_oe", {15'd0, bus.data_oe}, {15'd0, m_oe});
                check("cyc_write_count", write_count, m_count);
                check("cyc_violation", {15'd0, violation}, {15'd0, m_viol});
                if (m_do_known) check("cyc_data_out", {8'd0, bus.data_out}, {8'd0, m_do});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    logic [7:0] obs    [16];
    logic       oe_obs [16];

    task automatic idle();
        bus.n_ce1 = 1'b1; bus.n_we = 1'b1; bus.n_oe = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int n);
        bus.n_ce1 = 1'b0; bus.n_oe = 1'b0; bus.n_we = 1'b1; bus.address = a;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            obs[k]    = bus.data_out;
            oe_obs[k] = bus.data_oe;
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d, input int len,
                            output logic [15:0] mid_count);
        bus.n_ce1 = 1'b0; bus.n_we = 1'b0; bus.n_oe = 1'b1;
        bus.address = a; bus.data_in = d;
        repeat (len) @(negedge clk);
        bus.n_we = 1'b1;
        @(negedge clk);
        mid_count = write_count;
        bus.n_ce1 = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0]   mid;
        logic [AW-1:0] a;
        reset = 1'b1;
        bus.n_ce1 = 1'b1; bus.n_we = 1'b1; bus.n_oe = 1'b1;
        bus.address = '0; bus.data_in = '0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_data_out", {8'd0, bus.data_out}, 16'h00A5);
        check("reset_data_oe", {15'd0, bus.data_oe}, 16'd0);
        check("reset_write_count", write_count, 16'd0);
        check("reset_violation", {15'd0, violation}, 16'd0);
        reset = 1'b0;

        // Preload addr 0, then reset: contents survive, the counter does not.
        do_write(13'h0000, 8'h5A, 2, mid);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_clears_count", write_count, 16'd0);

        do_read(13'h0000, 7);
        for (int k = 0; k < 4; k++) check("t1_invalid_window", {8'd0, obs[k]}, 16'h00A5);
        check("t1_first_valid", {8'd0, obs[4]}, 16'h005A);
        check("t1_held_valid", {8'd0, obs[6]}, 16'h005A);
        for (int k = 0; k < 7; k++) check("t1_data_oe", {15'd0, oe_obs[k]}, 16'd1);
        idle();

        do_write(13'h1ABC, 8'h3C, 3, mid);
        check("t2_count_before_commit", mid, 16'd0);
        check("t2_count_after_commit", write_count, 16'd1);
        do_read(13'h1ABC, 6);
        check("t2_readback", {8'd0, obs[4]}, 16'h003C);
        idle();

        do_read(13'h0000, 2);
        do_read(13'h1ABC, 6);
        for (int k = 0; k < 4; k++) check("t4_restart_invalid", {8'd0, obs[k]}, 16'h00A5);
        check("t4_valid_after_restart", {8'd0, obs[4]}, 16'h003C);
        check("t4_no_violation", {15'd0, violation}, 16'd0);
        idle();

        for (int i = 0; i < 64; i++) begin
            a = (i < 48) ? AW'(i) : AW'(13'h1FF0 + (i - 48));
            do_write(a, a[7:0], 2, mid);
        end
        for (int i = 0; i < 64; i++) begin
            a = (i < 48) ? AW'(i) : AW'(13'h1FF0 + (i - 48));
            do_read(a, 5);
            check("t3_sweep_readback", {8'd0, obs[4]}, {8'd0, a[7:0]});
            idle();
        end
        check("t3_sweep_count", write_count, 16'd65);
        check("t3_no_violation", {15'd0, violation}, 16'd0);

        bus.n_ce1 = 1'b0; bus.n_we = 1'b0; bus.n_oe = 1'b1;
        bus.address = 13'h0010; bus.data_in = 8'h11;
        repeat (2) @(negedge clk);
        bus.address = 13'h0011; bus.data_in = 8'h22;
        repeat (2) @(negedge clk);
        bus.n_we = 1'b1;
        @(negedge clk);
        bus.n_ce1 = 1'b1;
        @(negedge clk);
        check("t5_violation_set", {15'd0, violation}, 16'd1);
        check("t5_count", write_count, 16'd66);
        check("t5_model_count", m_count, 16'd66);
        do_read(13'h0011, 5);
        check("t5_new_addr_value", {8'd0, obs[4]}, 16'h0022);
        idle();
        do_read(13'h0010, 5);
        check("t5_old_addr_untouched", {8'd0, obs[4]}, 16'h0010);
        idle();
        check("t5_violation_sticky", {15'd0, violation}, 16'd1);

        bus.n_ce1 = 1'b0; bus.n_we = 1'b0; bus.n_oe = 1'b1;
        bus.address = 13'h0020; bus.data_in = 8'h55;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_no_commit_count", write_count, 16'd0);
        check("t6_violation_cleared", {15'd0, violation}, 16'd0);
        do_read(13'h0020, 5);
        check("t6_prior_contents", {8'd0, obs[4]}, 16'h0020);
        idle();

        bus.n_ce1 = 1'b0; bus.n_we = 1'b0; bus.n_oe = 1'b0;
        bus.address = 13'h0021; bus.data_in = 8'h66;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_we_oe_data_oe", {15'd0, bus.data_oe}, 16'd0);
            check("t6_we_oe_data_out", {8'd0, bus.data_out}, 16'h00A5);
        end
        do_read(13'h0021, 7);
        for (int k = 0; k < 5; k++) check("t6_post_write_invalid", {8'd0, obs[k]}, 16'h00A5);
        check("t6_post_write_read", {8'd0, obs[5]}, 16'h0066);
        check("t6_count", write_count, 16'd1);
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
